// File: rtl/multicycle_reg_alu_core_if.sv
// Instruction/result bus of the multi-cycle register/ALU core.
// Ports (master = instruction source, slave = core):
//   instr_valid/instr_ready : accept handshake
//   op, rs, rt, rd, immediate, func_code : pre-decoded instruction fields
//   done, illegal           : retire pulse, unsupported-function flag
//   zero, result, read_data : ALU result/zero flag and memory load data
interface multicycle_reg_alu_core_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5
);
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        op;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
    logic [15:0]       immediate;
    logic [5:0]        func_code;
    logic              done;
    logic              illegal;
    logic              zero;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] read_data;

    modport master (
        output instr_valid, op, rs, rt, rd, immediate, func_code,
        input  instr_ready, done, illegal, zero, result, read_data
    );

    modport slave (
        input  instr_valid, op, rs, rt, rd, immediate, func_code,
        output instr_ready, done, illegal, zero, result, read_data
    );
endinterface

// File: rtl/multicycle_reg_alu_core.sv
// Multi-cycle datapath core: register file, sign-extend, ALU with funct
// decode and word data memory, sequenced by an internal FSM
// (IDLE -> DECODE -> EXEC -> MEM/WB -> IDLE), one instruction per handshake.
// Ports:
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset (clears FSM, registers, memory)
//   bus     : instruction/result bus, slave side
module multicycle_reg_alu_core #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned MEM_DEPTH = 64
) (
    input  logic clock,
    input  logic reset_n,
    multicycle_reg_alu_core_if.slave bus
);
    localparam int unsigned RA_W = $clog2(NUM_REGS);
    localparam int unsigned MA_W = $clog2(MEM_DEPTH);

    localparam logic [1:0] OP_R    = 2'b00;
    localparam logic [1:0] OP_LW   = 2'b01;
    localparam logic [1:0] OP_SW   = 2'b10;
    localparam logic [1:0] OP_ADDI = 2'b11;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [1:0]        r_op;
    logic [RA_W-1:0]   r_rs;
    logic [RA_W-1:0]   r_rt;
    logic [RA_W-1:0]   r_rd;
    logic [15:0]       r_imm16;
    logic [5:0]        r_func;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_imm;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_mem  [MEM_DEPTH];

    logic              r_ready;
    logic              r_done;
    logic              r_illegal;
    logic              r_zero;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_read_data;

    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W-1:0] w_alu;
    logic              w_slt;
    logic              w_func_ok;
    logic [MA_W-1:0]   w_mem_addr;
    logic              w_accept;

    // r_ready mirrors (state == IDLE)
    assign w_accept   = bus.instr_valid && r_ready;
    // byte address: drop the low two bits, wrap modulo the memory depth
    assign w_mem_addr = r_result[MA_W+1:2];

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = (r_op == OP_LW || r_op == OP_SW) ? S_MEM : S_WB;
            S_MEM:    w_next = (r_op == OP_LW) ? S_WB : S_IDLE;
            S_WB:     w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ALU: R-type decodes func_code, everything else is base + immediate
    always_comb begin
        w_alu_b   = (r_op == OP_R) ? r_b : r_imm;
        w_slt     = $signed(r_a) < $signed(w_alu_b);
        w_func_ok = 1'b1;
        w_alu     = '0;
        if (r_op != OP_R) begin
            w_alu = r_a + w_alu_b;
        end else begin
            case (r_func)
                F_ADD:   w_alu = r_a + w_alu_b;
                F_SUB:   w_alu = r_a - w_alu_b;
                F_AND:   w_alu = r_a & w_alu_b;
                F_OR:    w_alu = r_a | w_alu_b;
                F_SLT:   w_alu = DATA_W'(w_slt);
                default: w_func_ok = 1'b0;
            endcase
        end
    end

    // state register, datapath registers, register file and memory
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_imm16     <= '0;
            r_func      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
            r_zero      <= 1'b0;
            r_result    <= '0;
            r_read_data <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
            for (int j = 0; j < int'(MEM_DEPTH); j++) r_mem[j] <= '0;
        end else begin
            r_state   <= w_next;
            r_ready   <= (w_next == S_IDLE);
            // done/illegal are high for exactly the cycle spent in the last state
            r_done    <= (w_next == S_WB) || (w_next == S_MEM && r_op == OP_SW);
            r_illegal <= (w_next == S_WB) && (r_state == S_EXEC) &&
                         (r_op == OP_R) && !w_func_ok;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= bus.op;
                        r_rs    <= bus.rs;
                        r_rt    <= bus.rt;
                        r_rd    <= bus.rd;
                        r_imm16 <= bus.immediate;
                        r_func  <= bus.func_code;
                    end
                end
                S_DECODE: begin
                    r_a   <= (r_rs == '0) ? '0 : r_regs[r_rs];
                    r_b   <= (r_rt == '0) ? '0 : r_regs[r_rt];
                    r_imm <= DATA_W'($signed(r_imm16));
                end
                S_EXEC: begin
                    r_result <= w_alu;
                    r_zero   <= (w_alu == '0);
                end
                S_MEM: begin
                    if (r_op == OP_SW) r_mem[w_mem_addr] <= r_b;
                    else               r_read_data       <= r_mem[w_mem_addr];
                end
                S_WB: begin
                    // illegal R-type never writes (its func_code is still in r_func)
                    case (r_op)
                        OP_R: begin
                            if (r_rd != '0 && (r_func == F_ADD || r_func == F_SUB ||
                                r_func == F_AND || r_func == F_OR || r_func == F_SLT))
                                r_regs[r_rd] <= r_result;
                        end
                        OP_ADDI: if (r_rt != '0) r_regs[r_rt] <= r_result;
                        OP_LW:   if (r_rt != '0) r_regs[r_rt] <= r_read_data;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_ready = r_ready;
    assign bus.done        = r_done;
    assign bus.illegal     = r_illegal;
    assign bus.zero        = r_zero;
    assign bus.result      = r_result;
    assign bus.read_data   = r_read_data;
endmodule

// File: tb/tb_multicycle_reg_alu_core.sv
// Directed bench for multicycle_reg_alu_core: a 32-bit/32-reg/64-word
// instance and a 16-bit/8-reg/16-word instance share clock and reset.
module tb_multicycle_reg_alu_core;
    localparam logic [1:0] OP_R    = 2'b00;
    localparam logic [1:0] OP_LW   = 2'b01;
    localparam logic [1:0] OP_SW   = 2'b10;
    localparam logic [1:0] OP_ADDI = 2'b11;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_BAD = 6'b000000;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    multicycle_reg_alu_core_if #(.DATA_W(32), .RA_W(5)) bus32 ();
    multicycle_reg_alu_core_if #(.DATA_W(16), .RA_W(3)) bus16 ();

    multicycle_reg_alu_core #(.DATA_W(32), .NUM_REGS(32), .MEM_DEPTH(64)) u_dut32 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus32.slave)
    );

    multicycle_reg_alu_core #(.DATA_W(16), .NUM_REGS(8), .MEM_DEPTH(16)) u_dut16 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus16.slave)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] g_res;
    logic [31:0] g_rdat;
    logic        g_zero;
    logic        g_ill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? bus32.instr_ready : bus16.instr_ready;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 0) ? bus32.done : bus16.done;
    endfunction

    // present one instruction and return just after the accepting edge
    task automatic issue(input int sel, input logic [1:0] op, input int rs, input int rt,
                         input int rd, input logic [15:0] imm, input logic [5:0] fc);
        int guard = 0;
        @(negedge clock);
        while (!ready_of(sel) && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 20) check("ready_timeout", 32'(0), 32'(1));
        if (sel == 0) begin
            bus32.op = op; bus32.rs = 5'(rs); bus32.rt = 5'(rt); bus32.rd = 5'(rd);
            bus32.immediate = imm; bus32.func_code = fc; bus32.instr_valid = 1'b1;
        end else begin
            bus16.op = op; bus16.rs = 3'(rs); bus16.rt = 3'(rt); bus16.rd = 3'(rd);
            bus16.immediate = imm; bus16.func_code = fc; bus16.instr_valid = 1'b1;
        end
        @(posedge clock);
        #1;
        bus32.instr_valid = 1'b0;
        bus16.instr_valid = 1'b0;
    endtask

    // count falling edges after the accept edge until done is seen
    task automatic wait_done(input int sel, input string tag, input int exp_lat);
        int   lat = 0;
        logic d   = 1'b0;
        while (!d && lat < 10) begin
            @(negedge clock);
            lat++;
            d = done_of(sel);
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (sel == 0) begin
            g_res = bus32.result; g_rdat = bus32.read_data;
            g_zero = bus32.zero;  g_ill = bus32.illegal;
        end else begin
            g_res = 32'(bus16.result); g_rdat = 32'(bus16.read_data);
            g_zero = bus16.zero;       g_ill = bus16.illegal;
        end
    endtask

    task automatic run(input int sel, input string tag, input logic [1:0] op, input int rs,
                       input int rt, input int rd, input logic [15:0] imm, input logic [5:0] fc,
                       input int exp_lat, input logic [31:0] exp_res, input logic exp_ill);
        issue(sel, op, rs, rt, rd, imm, fc);
        wait_done(sel, tag, exp_lat);
        check({tag, "_res"}, g_res, exp_res);
        check({tag, "_ill"}, 32'(g_ill), 32'(exp_ill));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ready"}, 32'(bus32.instr_ready), 32'(1));
        check({tag, "_done"},  32'(bus32.done),        32'(0));
        check({tag, "_ill"},   32'(bus32.illegal),     32'(0));
        check({tag, "_zero"},  32'(bus32.zero),        32'(0));
        check({tag, "_res"},   bus32.result,           32'h0);
        check({tag, "_rdat"},  bus32.read_data,        32'h0);
        check({tag, "_rdy16"}, 32'(bus16.instr_ready), 32'(1));
        check({tag, "_res16"}, 32'(bus16.result),      32'h0);
    endtask

    initial begin
        bus32.instr_valid = 1'b0; bus32.op = '0; bus32.rs = '0; bus32.rt = '0; bus32.rd = '0;
        bus32.immediate = '0; bus32.func_code = '0;
        bus16.instr_valid = 1'b0; bus16.op = '0; bus16.rs = '0; bus16.rt = '0; bus16.rd = '0;
        bus16.immediate = '0; bus16.func_code = '0;

        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_cleared("reset");
        reset_n = 1'b1;

        // ---- 32-bit instance ----
        run(0, "addi_r5", OP_ADDI, 0, 5, 0, 16'h0014, F_ADD, 3, 32'd20, 1'b0);
        check("addi_r5_zero", 32'(g_zero), 32'(0));
        run(0, "add_r6", OP_R, 5, 0, 6, 16'h0, F_ADD, 3, 32'd20, 1'b0);
        run(0, "sw_r5", OP_SW, 0, 5, 0, 16'h0014, F_ADD, 3, 32'h14, 1'b0);
        run(0, "lw_r10", OP_LW, 0, 10, 0, 16'h0014, F_ADD, 4, 32'h14, 1'b0);
        check("lw_r10_rdat", g_rdat, 32'd20);
        run(0, "rd_r10", OP_R, 10, 0, 11, 16'h0, F_ADD, 3, 32'd20, 1'b0);
        run(0, "sub_r7", OP_R, 5, 10, 7, 16'h0, F_SUB, 3, 32'd0, 1'b0);
        check("sub_r7_zero", 32'(g_zero), 32'(1));
        run(0, "addi_r9", OP_ADDI, 0, 9, 0, 16'hFFFF, F_ADD, 3, 32'hFFFF_FFFF, 1'b0);
        run(0, "slt_neg", OP_R, 9, 0, 8, 16'h0, F_SLT, 3, 32'd1, 1'b0);
        run(0, "slt_pos", OP_R, 0, 9, 8, 16'h0, F_SLT, 3, 32'd0, 1'b0);
        run(0, "and_r12", OP_R, 9, 5, 12, 16'h0, F_AND, 3, 32'd20, 1'b0);
        run(0, "or_r12", OP_R, 5, 9, 12, 16'h0, F_OR, 3, 32'hFFFF_FFFF, 1'b0);
        run(0, "wrap_r13", OP_ADDI, 9, 13, 0, 16'h0001, F_ADD, 3, 32'd0, 1'b0);
        check("wrap_r13_zero", 32'(g_zero), 32'(1));
        // 0x114 -> word 0x45 mod 64 = 5
        run(0, "lw_alias", OP_LW, 0, 14, 0, 16'h0114, F_ADD, 4, 32'h114, 1'b0);
        check("lw_alias_rdat", g_rdat, 32'd20);
        run(0, "addi_r0", OP_ADDI, 0, 0, 0, 16'h0007, F_ADD, 3, 32'd7, 1'b0);
        run(0, "rd_r0", OP_R, 0, 0, 1, 16'h0, F_ADD, 3, 32'd0, 1'b0);
        run(0, "illegal", OP_R, 5, 5, 6, 16'h0, F_BAD, 3, 32'd0, 1'b1);
        run(0, "rd_r6", OP_R, 6, 0, 2, 16'h0, F_ADD, 3, 32'd20, 1'b0);

        // valid held high while busy: exactly one execution
        issue(0, OP_ADDI, 4, 4, 0, 16'h0001, F_ADD);
        bus32.instr_valid = 1'b1;
        wait_done(0, "hold", 3);
        bus32.instr_valid = 1'b0;
        check("hold_res", g_res, 32'd1);
        run(0, "rd_r4", OP_R, 4, 0, 2, 16'h0, F_ADD, 3, 32'd1, 1'b0);

        // reset during EXEC aborts the instruction
        issue(0, OP_ADDI, 0, 3, 0, 16'h0005, F_ADD);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check_cleared("mid_rst");
        reset_n = 1'b1;
        @(negedge clock);
        check("mid_rst_nodone", 32'(bus32.done), 32'(0));
        run(0, "rd_r3", OP_R, 3, 0, 1, 16'h0, F_ADD, 3, 32'd0, 1'b0);
        run(0, "rd_r5_clr", OP_R, 5, 0, 1, 16'h0, F_ADD, 3, 32'd0, 1'b0);
        check("rd_r5_clr_zero", 32'(g_zero), 32'(1));

        // ---- 16-bit / 8-reg / 16-word instance ----
        run(1, "n_addi_r5", OP_ADDI, 0, 5, 0, 16'h0014, F_ADD, 3, 32'd20, 1'b0);
        run(1, "n_add_r6", OP_R, 5, 0, 6, 16'h0, F_ADD, 3, 32'd20, 1'b0);
        run(1, "n_sw_r5", OP_SW, 0, 5, 0, 16'h0014, F_ADD, 3, 32'h14, 1'b0);
        run(1, "n_lw_r2", OP_LW, 0, 2, 0, 16'h0014, F_ADD, 4, 32'h14, 1'b0);
        check("n_lw_r2_rdat", g_rdat, 32'd20);
        run(1, "n_sub_r7", OP_R, 5, 2, 7, 16'h0, F_SUB, 3, 32'd0, 1'b0);
        check("n_sub_r7_zero", 32'(g_zero), 32'(1));
        run(1, "n_addi_r1", OP_ADDI, 0, 1, 0, 16'hFFFF, F_ADD, 3, 32'h0000_FFFF, 1'b0);
        run(1, "n_slt", OP_R, 1, 0, 4, 16'h0, F_SLT, 3, 32'd1, 1'b0);
        // 0x44 -> word 0x11 mod 16 = 1
        run(1, "n_sw_alias", OP_SW, 0, 1, 0, 16'h0044, F_ADD, 3, 32'h44, 1'b0);
        run(1, "n_lw_alias", OP_LW, 0, 3, 0, 16'h0004, F_ADD, 4, 32'h4, 1'b0);
        check("n_lw_alias_rdat", g_rdat, 32'h0000_FFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
